// File: rtl/fir_sync_fifo_if.sv
// Sample FIFO port bundle: write, read, status and error signals.
// master drives requests and data; slave is the FIFO itself.
interface fir_sync_fifo_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
);
  logic                    flush;
  logic                    wen;
  logic signed [WIDTH-1:0] din;
  logic                    full;
  logic                    almost_full;
  logic                    ren;
  logic signed [WIDTH-1:0] dout;
  logic                    dout_vld;
  logic                    empty;
  logic                    almost_empty;
  logic [ADDR_W:0]         count;
  logic                    overflow;
  logic                    underflow;
  logic                    err_clr;

  modport master (
    output flush, wen, din, ren, err_clr,
    input  full, almost_full, dout, dout_vld,
    input  empty, almost_empty, count,
    input  overflow, underflow
  );

  modport slave (
    input  flush, wen, din, ren, err_clr,
    output full, almost_full, dout, dout_vld,
    output empty, almost_empty, count,
    output overflow, underflow
  );
endinterface

// File: rtl/fir_sync_fifo.sv
// Single-clock sample FIFO with watermarks, sticky errors and flush.
// Define FIR_SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module fir_sync_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int AF_THRESH = 56,
  parameter int AE_THRESH = 8
) (
  input logic            clk,
  input logic            rstn,
  fir_sync_fifo_if.slave bus
);
  localparam logic [ADDR_W:0] FULL_C =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C =
    (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C =
    (ADDR_W+1)'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [ADDR_W:0]  cnt;
  logic             is_full;
  logic             is_empty;
  logic             wr_acc;
  logic             rd_acc;
  logic             ovf_q;
  logic             unf_q;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] dout_w;
  logic             vld_w;

  // wrap bit makes the difference exact over 0..DEPTH
  assign cnt      = wr_ptr - rd_ptr;
  assign is_full  = (cnt == FULL_C);
  assign is_empty = (wr_ptr == rd_ptr);
  assign head     = mem[rd_ptr[ADDR_W-1:0]];

  assign wr_acc = bus.wen & ~is_full & ~bus.flush;
  assign rd_acc = bus.ren & ~is_empty & ~bus.flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= bus.din;
  end

  // a new rejection wins over a same-cycle clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (bus.wen & is_full & ~bus.flush)
             | (ovf_q & ~bus.err_clr);
      unf_q <= (bus.ren & is_empty & ~bus.flush)
             | (unf_q & ~bus.err_clr);
    end
  end

`ifdef FIR_SYNC_FIFO_FWFT_EN
  logic [WIDTH-1:0] hold_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hold_q <= '0;
    else       hold_q <= dout_w;
  end

  assign dout_w = is_empty ? hold_q : head;
  assign vld_w  = ~is_empty;
`else
  logic [WIDTH-1:0] dout_q;
  logic             vld_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= rd_acc;
      if (rd_acc) dout_q <= head;
    end
  end

  assign dout_w = dout_q;
  assign vld_w  = vld_q;
`endif

  assign bus.dout         = dout_w;
  assign bus.dout_vld     = vld_w;
  assign bus.count        = cnt;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule
